// File: rtl/or_rows_stream.sv
// Streaming column-wise OR/AND/XOR reducer over frames of up to ROWS rows.
// Ports: clk, resetn, In{Valid,Ready,Data,Last}, Op, Out{Valid,Ready,Data,Count}.
module or_rows_stream #(
  parameter int COLS = 2,
  parameter int ROWS = 8,
  localparam int CW = $clog2(ROWS + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            InValid,
  output logic            InReady,
  input  logic [COLS-1:0] InData,
  input  logic            InLast,
  input  logic [1:0]      Op,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [COLS-1:0] OutData,
  output logic [CW-1:0]   OutCount
);

  typedef enum logic [1:0] {
    EMPTY,
    ACCUM,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [COLS-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      opr_q, opr_d;
  logic [CW-1:0]   cnt_inc;

  function automatic logic [COLS-1:0] fold(
    input logic [1:0]      op,
    input logic [COLS-1:0] a,
    input logic [COLS-1:0] b
  );
    logic [COLS-1:0] r;
    unique case (1'b1)
      (op == 2'b01): r = a & b;
      (op == 2'b10): r = a ^ b;
      default:       r = a | b;
    endcase
    return r;
  endfunction

  assign cnt_inc  = cnt_q + 1'b1;
  assign OutValid = (state_q == DONE);
  // While a result is pending a new row may only enter as it leaves.
  assign InReady  = (state_q == DONE) ? OutReady : 1'b1;
  assign OutData  = acc_q;
  assign OutCount = cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    opr_d   = opr_q;
    unique case (state_q)
      EMPTY: begin
        if (InValid) begin
          acc_d   = InData;
          opr_d   = Op;
          cnt_d   = CW'(1);
          state_d = (InLast || ROWS == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (InValid) begin
          acc_d = fold(opr_q, acc_q, InData);
          cnt_d = cnt_inc;
          if (InLast || cnt_inc == CW'(ROWS))
            state_d = DONE;
        end
      end
      DONE: begin
        if (OutReady) begin
          if (InValid) begin
            acc_d   = InData;
            opr_d   = Op;
            cnt_d   = CW'(1);
            state_d = (InLast || ROWS == 1) ? DONE : ACCUM;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      opr_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      opr_q   <= opr_d;
    end
  end

endmodule

// File: tb/tb_or_rows_stream.sv
// Directed bench for or_rows_stream: table of per-cycle vectors
// plus hand sequences for reset and the ROWS=1 build.
module tb_or_rows_stream;

  logic       clk = 1'b0;
  logic       resetn;
  logic       iv, il, ordy;
  logic [3:0] id;
  logic [1:0] op;
  logic       ir, ov;
  logic [3:0] od;
  logic [2:0] oc;

  logic       iv1, il1, ordy1;
  logic [3:0] id1;
  logic [1:0] op1;
  logic       ir1, ov1;
  logic [3:0] od1;
  logic       oc1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  or_rows_stream #(.COLS(4), .ROWS(4)) dut (
    .clk(clk), .resetn(resetn),
    .InValid(iv), .InReady(ir), .InData(id),
    .InLast(il), .Op(op),
    .OutValid(ov), .OutReady(ordy),
    .OutData(od), .OutCount(oc)
  );

  or_rows_stream #(.COLS(4), .ROWS(1)) dut1 (
    .clk(clk), .resetn(resetn),
    .InValid(iv1), .InReady(ir1), .InData(id1),
    .InLast(il1), .Op(op1),
    .OutValid(ov1), .OutReady(ordy1),
    .OutData(od1), .OutCount(oc1)
  );

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       l;
    logic [1:0] op;
    logic       ordy;
    logic       eov;
    logic [3:0] eod;
    logic [2:0] eoc;
    logic       eir;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [3:0] d,
                     input logic l, input logic [1:0] o,
                     input logic r, input logic eov,
                     input logic [3:0] eod,
                     input logic [2:0] eoc,
                     input logic eir);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.op = o; t.ordy = r;
    t.eov = eov; t.eod = eod; t.eoc = eoc; t.eir = eir;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    iv = 0; id = 0; il = 0; op = 0; ordy = 1;
    iv1 = 0; id1 = 0; il1 = 0; op1 = 0; ordy1 = 1;

    // OR frame, 4 rows, no InLast
    add(0, 4'h0, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h1, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h2, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h0, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h8, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(0, 4'h0, 0, 2'b00, 1, 1, 4'hB, 4, 1);
    // AND frame, InLast on row 3, Op flips to XOR mid-frame
    add(1, 4'hF, 0, 2'b01, 1, 0, 4'h0, 0, 1);
    add(1, 4'hD, 0, 2'b10, 1, 0, 4'h0, 0, 1);
    add(1, 4'h7, 1, 2'b10, 1, 0, 4'h0, 0, 1);
    add(0, 4'h0, 0, 2'b00, 1, 1, 4'h5, 3, 1);
    // XOR frame
    add(1, 4'hC, 0, 2'b10, 1, 0, 4'h0, 0, 1);
    add(1, 4'hA, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h6, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h0, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(0, 4'h0, 0, 2'b00, 1, 1, 4'h0, 4, 1);
    // Backpressure: 1011 held 5 cycles, offered rows refused
    add(1, 4'h1, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h2, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h0, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h8, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    for (int i = 0; i < 5; i++)
      add(1, 4'hF, 1, 2'b01, 0, 1, 4'hB, 4, 0);
    add(1, 4'h4, 0, 2'b00, 1, 1, 4'hB, 4, 1);
    add(1, 4'h1, 1, 2'b00, 1, 0, 4'h0, 0, 1);
    add(0, 4'h0, 0, 2'b00, 1, 1, 4'h5, 2, 1);
    // Streaming: three 4-row frames back to back
    add(1, 4'h1, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h2, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h4, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h8, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'hE, 0, 2'b01, 1, 1, 4'hF, 4, 1);
    add(1, 4'h7, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'hF, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'hF, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h3, 0, 2'b10, 1, 1, 4'h6, 4, 1);
    add(1, 4'h5, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h0, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(1, 4'h8, 0, 2'b00, 1, 0, 4'h0, 0, 1);
    add(0, 4'h0, 0, 2'b00, 1, 1, 4'hE, 4, 1);
    add(0, 4'h0, 0, 2'b00, 1, 0, 4'h0, 0, 1);

    repeat (2) @(negedge clk);
    chk("rst_ov", ov, 0);
    chk("rst_od", od, 0);
    chk("rst_oc", oc, 0);
    chk("rst1_ov", ov1, 0);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      iv = tbl[i].v; id = tbl[i].d; il = tbl[i].l;
      op = tbl[i].op; ordy = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_ov", i), ov, tbl[i].eov);
      chk($sformatf("v%0d_ir", i), ir, tbl[i].eir);
      if (tbl[i].eov) begin
        chk($sformatf("v%0d_od", i), od, tbl[i].eod);
        chk($sformatf("v%0d_oc", i), oc, tbl[i].eoc);
      end
    end

    // Reset mid-frame after two OR rows
    @(negedge clk);
    iv = 1; id = 4'hA; il = 0; op = 2'b00;
    @(negedge clk);
    id = 4'h4;
    @(negedge clk);
    iv = 0;
    #1;
    chk("pre_rst_od", od, 4'hE);
    chk("pre_rst_oc", oc, 2);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_ov", ov, 0);
    chk("mid_rst_od", od, 0);
    chk("mid_rst_oc", oc, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("post_rst_ir", ir, 1);
    @(negedge clk);
    iv = 1; id = 4'h4; il = 0; op = 2'b00;
    @(negedge clk);
    id = 4'h1; il = 1;
    @(negedge clk);
    iv = 0; il = 0;
    #1;
    chk("fresh_ov", ov, 1);
    chk("fresh_od", od, 4'h5);
    chk("fresh_oc", oc, 2);

    // ROWS=1 build: every row is its own frame
    @(negedge clk);
    iv1 = 1; id1 = 4'h9; il1 = 0; op1 = 2'b01;
    #1;
    chk("r1_ir", ir1, 1);
    chk("r1_ov0", ov1, 0);
    @(negedge clk);
    iv1 = 0;
    #1;
    chk("r1_ov", ov1, 1);
    chk("r1_od", od1, 4'h9);
    chk("r1_oc", oc1, 1);
    @(negedge clk);
    #1;
    chk("r1_ov_clr", ov1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
